// File: rtl/fetch_controller_if.sv
// Instruction-memory request/response bus between the fetch controller (master) and imem (slave).
interface fetch_controller_if;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic        imemValid;
  logic [31:0] imemData;

  modport master (
    output imemReq,
    output imemAddr,
    input  imemReady,
    input  imemValid,
    input  imemData
  );

  modport slave (
    input  imemReq,
    input  imemAddr,
    output imemReady,
    output imemValid,
    output imemData
  );
endinterface

// File: rtl/fetch_controller.sv
// IF-stage sequencer: owns the PC, runs the imem request/response handshake and presents words to IF/ID.
// Optional macro FETCH_TIMEOUT_EN adds a per-fetch watchdog, a sticky fetchError and a HALT state.
module fetch_controller #(
  parameter logic [31:0] RESET_PC       = 32'h0000_3000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        newPC,
  input  logic               redirect,
  input  logic               stallIF,
  fetch_controller_if.master imem,
  output logic [31:0]        pc,
  output logic               instrValid,
  output logic [31:0]        instruction,
  output logic [31:0]        instrPC,
  output logic               fetchError
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP,
`ifdef FETCH_TIMEOUT_EN
    S_HALT,
`endif
    S_ISSUE
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_instr_valid;
  logic [31:0] r_instruction;
  logic [31:0] r_instr_pc;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_timer;
  logic       r_fetch_error;
  logic       w_stay;

  // A waiting state that will not change this cycle keeps the watchdog running.
  always_comb begin
    w_stay = 1'b0;
    case (r_state)
      S_REQ:   w_stay = !imem.imemReady;
      S_WAIT:  w_stay = !imem.imemValid;
      S_DROP:  w_stay = !imem.imemValid;
      default: w_stay = 1'b0;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_instr_valid <= 1'b0;
      r_instruction <= '0;
      r_instr_pc    <= '0;
`ifdef FETCH_TIMEOUT_EN
      r_timer       <= '0;
      r_fetch_error <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_REQ;
        end

        S_REQ: begin
          if (imem.imemReady && redirect) begin
            // The accepted address is already stale; its response must be swallowed.
            r_pc    <= newPC;
            r_state <= S_DROP;
          end else if (imem.imemReady) begin
            r_state <= S_WAIT;
          end else if (redirect) begin
            r_pc <= newPC;
          end
        end

        S_WAIT: begin
          if (imem.imemValid && redirect) begin
            r_pc    <= newPC;
            r_state <= S_REQ;
          end else if (imem.imemValid) begin
            r_instruction <= imem.imemData;
            r_instr_pc    <= r_pc;
            r_instr_valid <= 1'b1;
            r_state       <= S_ISSUE;
          end else if (redirect) begin
            r_pc    <= newPC;
            r_state <= S_DROP;
          end
        end

        S_DROP: begin
          if (redirect) begin
            r_pc <= newPC;
          end
          if (imem.imemValid) begin
            r_state <= S_REQ;
          end
        end

        S_ISSUE: begin
          // Redirect wins over a stall so a flushed word never lingers in IF/ID.
          if (redirect || !stallIF) begin
            r_instr_valid <= 1'b0;
            r_pc          <= newPC;
            r_state       <= S_REQ;
          end
        end

        default: begin
          r_state <= r_state;
        end
      endcase

`ifdef FETCH_TIMEOUT_EN
      if (w_stay && !redirect) begin
        if (r_timer == TIMEOUT_LAST) begin
          r_state       <= S_HALT;
          r_fetch_error <= 1'b1;
          r_timer       <= '0;
        end else begin
          r_timer <= r_timer + 8'd1;
        end
      end else begin
        r_timer <= '0;
      end
`endif
    end
  end

  assign imem.imemReq  = (r_state == S_REQ);
  assign imem.imemAddr = r_pc;
  assign pc            = r_pc;
  assign instrValid    = r_instr_valid;
  assign instruction   = r_instruction;
  assign instrPC       = r_instr_pc;

`ifdef FETCH_TIMEOUT_EN
  assign fetchError = r_fetch_error;
`else
  assign fetchError = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a scoreboard of expected {instruction, instrPC} per issued word.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic        stallIF;
  logic [31:0] target;
  logic [31:0] newPC;
  logic [31:0] pc;
  logic        instrValid;
  logic [31:0] instruction;
  logic [31:0] instrPC;
  logic        fetchError;

  fetch_controller_if imem_bus ();

  fetch_controller dut (
    .clk         (clk),
    .reset       (reset),
    .newPC       (newPC),
    .redirect    (redirect),
    .stallIF     (stallIF),
    .imem        (imem_bus),
    .pc          (pc),
    .instrValid  (instrValid),
    .instruction (instruction),
    .instrPC     (instrPC),
    .fetchError  (fetchError)
  );

  always #5 clk = ~clk;

  // Next-PC logic stand-in: sequential pc+4 unless a redirect target is being applied.
  assign newPC = redirect ? target : pc + 32'd4;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];
  logic        prev_iv  = 1'b0;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starting in REQ at exp_pc: accept, return data next cycle, land in ISSUE.
  task automatic do_fetch(input logic [31:0] data, input logic [31:0] exp_pc);
    check1("fetch_req", imem_bus.imemReq, 1'b1);
    check32("fetch_addr", imem_bus.imemAddr, exp_pc);
    imem_bus.imemReady = 1'b1;
    tick();
    imem_bus.imemReady = 1'b0;
    imem_bus.imemValid = 1'b1;
    imem_bus.imemData  = data;
    exp_q.push_back({data, exp_pc});
    tick();
    imem_bus.imemValid = 1'b0;
    check1("fetch_instrValid", instrValid, 1'b1);
    $display("fetch pc=%h data=%h instr=%h instrPC=%h", exp_pc, data, instruction, instrPC);
  endtask

  // Scoreboard consumer: every new instrValid pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (instrValid && !prev_iv) begin
      n_assert++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL spurious_instrValid observed=1 expected=0 instrPC=%h", instrPC);
      end
      if (exp_q.size() != 0) begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check32("sb_instruction", instruction, e[63:32]);
        check32("sb_instrPC", instrPC, e[31:0]);
      end
    end
    prev_iv = instrValid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset              = 1'b1;
    redirect           = 1'b0;
    stallIF            = 1'b0;
    target             = '0;
    imem_bus.imemReady = 1'b0;
    imem_bus.imemValid = 1'b0;
    imem_bus.imemData  = '0;
    tick();
    tick();

    // Reset state
    check32("rst_pc", pc, 32'h0000_3000);
    check1("rst_req", imem_bus.imemReq, 1'b0);
    check1("rst_instrValid", instrValid, 1'b0);
    check32("rst_instruction", instruction, 32'h0);
    check32("rst_instrPC", instrPC, 32'h0);
    check1("rst_fetchError", fetchError, 1'b0);
    $display("reset pc=%h req=%b", pc, imem_bus.imemReq);

    // 1: first fetch, then sequential next request
    reset = 1'b0;
    tick();
    do_fetch(32'h2402_0001, 32'h0000_3000);
    check32("t1_instruction", instruction, 32'h2402_0001);
    tick();
    check1("t1_next_req", imem_bus.imemReq, 1'b1);
    check32("t1_next_addr", imem_bus.imemAddr, 32'h0000_3004);
    check1("t1_iv_drop", instrValid, 1'b0);

    // 2: stall holds ISSUE for 4 cycles
    do_fetch(32'h8C43_0000, 32'h0000_3004);
    stallIF = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check1("t2_stall_iv", instrValid, 1'b1);
      check1("t2_stall_req", imem_bus.imemReq, 1'b0);
      check32("t2_stall_pc", pc, 32'h0000_3004);
      check32("t2_stall_instr", instruction, 32'h8C43_0000);
      check32("t2_stall_instrPC", instrPC, 32'h0000_3004);
    end
    stallIF = 1'b0;
    tick();
    check1("t2_resume_req", imem_bus.imemReq, 1'b1);
    check32("t2_resume_addr", imem_bus.imemAddr, 32'h0000_3008);
    $display("stall released, next addr=%h", imem_bus.imemAddr);

    // 3: redirect in WAIT, late data is dropped
    imem_bus.imemReady = 1'b1;
    tick();
    imem_bus.imemReady = 1'b0;
    redirect = 1'b1;
    target   = 32'h0000_3100;
    tick();
    redirect = 1'b0;
    check1("t3_drop_req", imem_bus.imemReq, 1'b0);
    check32("t3_drop_pc", pc, 32'h0000_3100);
    imem_bus.imemValid = 1'b1;
    imem_bus.imemData  = 32'hDEAD_BEEF;
    tick();
    imem_bus.imemValid = 1'b0;
    check1("t3_iv", instrValid, 1'b0);
    check1("t3_req", imem_bus.imemReq, 1'b1);
    check32("t3_addr", imem_bus.imemAddr, 32'h0000_3100);
    $display("wait-redirect addr=%h", imem_bus.imemAddr);

    // 4: redirect and valid in the same WAIT cycle
    imem_bus.imemReady = 1'b1;
    tick();
    imem_bus.imemReady = 1'b0;
    imem_bus.imemValid = 1'b1;
    imem_bus.imemData  = 32'h1111_1111;
    redirect = 1'b1;
    target   = 32'h0000_3200;
    tick();
    redirect = 1'b0;
    imem_bus.imemValid = 1'b0;
    check1("t4_iv", instrValid, 1'b0);
    check1("t4_req", imem_bus.imemReq, 1'b1);
    check32("t4_addr", imem_bus.imemAddr, 32'h0000_3200);
    $display("valid+redirect addr=%h", imem_bus.imemAddr);

    // 5: redirect beats stall in ISSUE
    do_fetch(32'h2222_2222, 32'h0000_3200);
    redirect = 1'b1;
    stallIF  = 1'b1;
    target   = 32'h0000_3300;
    tick();
    redirect = 1'b0;
    stallIF  = 1'b0;
    check1("t5_iv", instrValid, 1'b0);
    check1("t5_req", imem_bus.imemReq, 1'b1);
    check32("t5_addr", imem_bus.imemAddr, 32'h0000_3300);
    $display("issue redirect+stall addr=%h", imem_bus.imemAddr);

    // Redirect in REQ before acceptance; stray valid in REQ ignored
    redirect = 1'b1;
    target   = 32'h0000_3400;
    tick();
    redirect = 1'b0;
    check1("req_redir_req", imem_bus.imemReq, 1'b1);
    check32("req_redir_addr", imem_bus.imemAddr, 32'h0000_3400);
    imem_bus.imemValid = 1'b1;
    imem_bus.imemData  = 32'h5555_5555;
    tick();
    imem_bus.imemValid = 1'b0;
    check1("req_stray_req", imem_bus.imemReq, 1'b1);
    check1("req_stray_iv", instrValid, 1'b0);

    // Redirect with acceptance -> DROP, redirect again in DROP
    imem_bus.imemReady = 1'b1;
    redirect = 1'b1;
    target   = 32'h0000_3500;
    tick();
    imem_bus.imemReady = 1'b0;
    check1("drop_req", imem_bus.imemReq, 1'b0);
    check32("drop_pc", pc, 32'h0000_3500);
    target = 32'h0000_3600;
    tick();
    redirect = 1'b0;
    check1("drop2_req", imem_bus.imemReq, 1'b0);
    check32("drop2_pc", pc, 32'h0000_3600);
    imem_bus.imemValid = 1'b1;
    tick();
    imem_bus.imemValid = 1'b0;
    check1("drop_exit_req", imem_bus.imemReq, 1'b1);
    check32("drop_exit_addr", imem_bus.imemAddr, 32'h0000_3600);
    check1("drop_exit_iv", instrValid, 1'b0);
    $display("drop sequence addr=%h", imem_bus.imemAddr);

    // Reset mid-fetch abandons the transaction
    imem_bus.imemReady = 1'b1;
    tick();
    imem_bus.imemReady = 1'b0;
    reset = 1'b1;
    tick();
    check32("midrst_pc", pc, 32'h0000_3000);
    check1("midrst_req", imem_bus.imemReq, 1'b0);
    reset = 1'b0;
    imem_bus.imemValid = 1'b1;
    tick();
    imem_bus.imemValid = 1'b0;
    check1("midrst_iv", instrValid, 1'b0);
    check1("midrst_req2", imem_bus.imemReq, 1'b1);
    check32("midrst_addr", imem_bus.imemAddr, 32'h0000_3000);
    $display("mid-fetch reset addr=%h", imem_bus.imemAddr);

    // PC wraps modulo 2^32
    redirect = 1'b1;
    target   = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    do_fetch(32'h3333_3333, 32'hFFFF_FFFC);
    tick();
    check32("wrap_addr", imem_bus.imemAddr, 32'h0000_0000);

    // Unaligned pc passes through
    redirect = 1'b1;
    target   = 32'h0000_3001;
    tick();
    redirect = 1'b0;
    check32("unaligned_addr", imem_bus.imemAddr, 32'h0000_3001);

    // 6: memory never ready
`ifdef FETCH_TIMEOUT_EN
    repeat (254) tick();
    check1("to_before_err", fetchError, 1'b0);
    check1("to_before_req", imem_bus.imemReq, 1'b1);
    tick();
    check1("to_err", fetchError, 1'b1);
    check1("to_halt_req", imem_bus.imemReq, 1'b0);
    check1("to_halt_iv", instrValid, 1'b0);
    redirect = 1'b1;
    target   = 32'h0000_4000;
    tick();
    redirect = 1'b0;
    check32("to_halt_pc", pc, 32'h0000_3001);
    check1("to_halt_err", fetchError, 1'b1);
    check1("to_halt_req2", imem_bus.imemReq, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check1("to_rst_err", fetchError, 1'b0);
`else
    repeat (300) tick();
    check1("noto_err", fetchError, 1'b0);
    check1("noto_req", imem_bus.imemReq, 1'b1);
    check32("noto_addr", imem_bus.imemAddr, 32'h0000_3001);
`endif
    $display("timeout phase fetchError=%b req=%b", fetchError, imem_bus.imemReq);

    tick();
    check32("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
